// File: rtl/cam_line_packer.sv
// Camera line packer: samples vsync/hsync/pixels and packs them into FIFO words.
// Define CAM_LINE_PACKER_BIG_ENDIAN_EN to place the first pixel in the top lane.
module cam_line_packer #(
  parameter int PIX_W  = 8,
  parameter int DATA_W = 32,
  parameter int LINE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [LINE_W-1:0] i_line_count,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic [PIX_W-1:0]  i_pix_data,
  input  logic [1:0]        i_wr_ready,
  output logic [1:0]        o_wr_activate,
  input  logic [23:0]       i_wr_size,
  output logic              o_wr_stb,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_captured,
  output logic [LINE_W-1:0] o_lines,
  output logic              o_overflow,
  output logic [LINE_W-1:0] o_dropped
);
  localparam int PPW = DATA_W / PIX_W;
  localparam int KW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PPW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WFRAME, S_WLINE, S_CAPT,
    S_FLUSH, S_DROP, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic              r_vs_q, r_hs_q;
  logic [KW-1:0]     r_k;
  logic [23:0]       r_wcnt;
  logic              r_full;
  logic [DATA_W-1:0] r_pack;

  logic              w_vs_rise, w_hs_rise;
  logic              w_room, w_last, w_budget, w_end;
  logic [KW-1:0]     w_lane;
  logic [DATA_W-1:0] w_ins;
  logic [LINE_W-1:0] w_lines_inc, w_drop_inc;
  logic              w_claim, w_store, w_flush;
  logic              w_release, w_drop_end, w_fstart;

  assign w_vs_rise = i_vsync & ~r_vs_q;
  assign w_hs_rise = i_hsync & ~r_hs_q;
  assign w_room    = r_wcnt < i_wr_size;
  assign w_last    = r_k == K_LAST;

`ifdef CAM_LINE_PACKER_BIG_ENDIAN_EN
  assign w_lane = K_LAST - r_k;
`else
  assign w_lane = r_k;
`endif

  assign w_ins = r_pack |
    (DATA_W'(i_pix_data) << (PIX_W * int'(w_lane)));

  assign w_lines_inc = (&o_lines) ? o_lines
                     : o_lines + LINE_W'(1);
  assign w_drop_inc  = (&o_dropped) ? o_dropped
                     : o_dropped + LINE_W'(1);
  assign w_budget = (i_line_count != '0) &&
                    (w_lines_inc == i_line_count);
  assign w_end    = w_budget | ~i_vsync;

  assign o_busy     = r_state != S_IDLE;
  assign o_captured = r_state == S_DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_claim    = 1'b0;
    w_store    = 1'b0;
    w_flush    = 1'b0;
    w_release  = 1'b0;
    w_drop_end = 1'b0;
    w_fstart   = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_enable) w_next = S_WFRAME;
      S_WFRAME: begin
        if (!i_enable) begin
          w_next = S_IDLE;
        end else if (w_vs_rise) begin
          w_fstart = 1'b1;
          w_next   = S_WLINE;
        end
      end
      S_WLINE: begin
        if (!i_vsync) begin
          w_next = S_DONE;
        end else if (w_hs_rise) begin
          if (|i_wr_ready) begin
            w_claim = 1'b1;
            w_store = 1'b1;
            w_next  = S_CAPT;
          end else begin
            w_next = S_DROP;
          end
        end
      end
      S_CAPT: begin
        // vsync dropping mid-line closes the line like hsync
        if (!i_hsync || !i_vsync) begin
          w_flush = 1'b1;
          w_next  = S_FLUSH;
        end else begin
          w_store = 1'b1;
        end
      end
      S_FLUSH: begin
        w_release = 1'b1;
        w_next    = w_end ? S_DONE : S_WLINE;
      end
      S_DROP: begin
        if (!i_hsync || !i_vsync) begin
          w_drop_end = 1'b1;
          w_next     = w_end ? S_DONE : S_WLINE;
        end
      end
      S_DONE: w_next = i_enable ? S_WFRAME : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q        <= 1'b0;
      r_hs_q        <= 1'b0;
      r_k           <= '0;
      r_wcnt        <= '0;
      r_full        <= 1'b0;
      r_pack        <= '0;
      o_wr_activate <= '0;
      o_wr_stb      <= 1'b0;
      o_wr_data     <= '0;
      o_lines       <= '0;
      o_overflow    <= 1'b0;
      o_dropped     <= '0;
    end else begin
      r_vs_q   <= i_vsync;
      r_hs_q   <= i_hsync;
      o_wr_stb <= 1'b0;
      if (w_fstart) begin
        o_lines    <= '0;
        o_dropped  <= '0;
        o_overflow <= 1'b0;
      end
      if (w_claim)
        o_wr_activate <= i_wr_ready[0] ? 2'b01 : 2'b10;
      if (w_store && !r_full) begin
        if (w_last) begin
          r_pack <= '0;
          r_k    <= '0;
          if (w_room) begin
            o_wr_stb  <= 1'b1;
            o_wr_data <= w_ins;
            r_wcnt    <= r_wcnt + 24'd1;
          end else begin
            o_overflow <= 1'b1;
            r_full     <= 1'b1;
          end
        end else begin
          r_pack <= w_ins;
          r_k    <= r_k + KW'(1);
        end
      end
      if (w_flush && r_k != '0) begin
        r_pack <= '0;
        r_k    <= '0;
        if (w_room) begin
          o_wr_stb  <= 1'b1;
          o_wr_data <= r_pack;
          r_wcnt    <= r_wcnt + 24'd1;
        end else begin
          o_overflow <= 1'b1;
        end
      end
      if (w_release) begin
        o_wr_activate <= '0;
        o_lines       <= w_lines_inc;
        r_k           <= '0;
        r_wcnt        <= '0;
        r_full        <= 1'b0;
        r_pack        <= '0;
      end
      if (w_drop_end) begin
        o_lines   <= w_lines_inc;
        o_dropped <= w_drop_inc;
      end
    end
  end
endmodule

// File: tb/tb_cam_line_packer.sv
// Bench for cam_line_packer: line-vector table plus hand-written frame sequences.
// Words are checked through a queue filled from a packing model.
`timescale 1ns/1ps
module tb_cam_line_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [15:0] i_line_count;
  logic        i_vsync, i_hsync;
  logic [7:0]  i_pix_data;
  logic [1:0]  i_wr_ready;
  logic [23:0] i_wr_size;
  logic [1:0]  o_wr_activate;
  logic        o_wr_stb, o_busy, o_captured, o_overflow;
  logic [31:0] o_wr_data;
  logic [15:0] o_lines, o_dropped;

  logic [15:0] pix16;
  logic [1:0]  act16;
  logic        stb16, busy16, cap16, ovf16;
  logic [31:0] data16;
  logic [15:0] lines16, dropped16;

  int n_chk = 0;
  int n_fail = 0;
  int n_stb = 0;
  int n_cap = 0;
  logic [31:0] exp_q[$];
  logic [31:0] q16[$];

  always #5 clk = ~clk;
  assign pix16 = {i_pix_data, i_pix_data};

  cam_line_packer u_dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .i_line_count(i_line_count), .i_vsync(i_vsync),
    .i_hsync(i_hsync), .i_pix_data(i_pix_data),
    .i_wr_ready(i_wr_ready), .o_wr_activate(o_wr_activate),
    .i_wr_size(i_wr_size), .o_wr_stb(o_wr_stb),
    .o_wr_data(o_wr_data), .o_busy(o_busy),
    .o_captured(o_captured), .o_lines(o_lines),
    .o_overflow(o_overflow), .o_dropped(o_dropped)
  );

  cam_line_packer #(.PIX_W(16), .DATA_W(32), .LINE_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .i_line_count(i_line_count), .i_vsync(i_vsync),
    .i_hsync(i_hsync), .i_pix_data(pix16),
    .i_wr_ready(i_wr_ready), .o_wr_activate(act16),
    .i_wr_size(i_wr_size), .o_wr_stb(stb16),
    .o_wr_data(data16), .o_busy(busy16),
    .o_captured(cap16), .o_lines(lines16),
    .o_overflow(ovf16), .o_dropped(dropped16)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wr_stb) begin
        n_stb++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_stb: got %0h expected none", o_wr_data);
        end else begin
          check("wr_data", o_wr_data, exp_q.pop_front());
        end
        check("act_at_stb", o_wr_activate != 2'b00, 1);
      end
      if (o_captured) n_cap++;
      if (stb16) q16.push_back(data16);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] model_word(logic [7:0] base,
      logic [7:0] stride, int first, int npix);
    logic [31:0] w;
    logic [7:0]  p;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      if (first + j < npix) begin
        p = base + 8'(first + j) * stride;
`ifdef CAM_LINE_PACKER_BIG_ENDIAN_EN
        w[(3-j)*8 +: 8] = p;
`else
        w[j*8 +: 8] = p;
`endif
      end
    end
    return w;
  endfunction

  task automatic push_line(int npix, logic [7:0] base,
      logic [7:0] stride, int size);
    for (int w = 0; w < (npix + 3) / 4; w++)
      if (w < size) exp_q.push_back(model_word(base, stride, w * 4, npix));
  endtask

  task automatic send_line(int npix, logic [7:0] base, logic [7:0] stride);
    for (int i = 0; i < npix; i++) begin
      i_hsync    = 1'b1;
      i_pix_data = base + 8'(i) * stride;
      step();
    end
    i_hsync    = 1'b0;
    i_pix_data = '0;
    step(4);
  endtask

  task automatic run_frame(int nl, int npix, logic [7:0] base,
      logic [7:0] stride, int size, int drop_l);
    int c0;
    int t;
    c0 = n_cap;
    i_wr_size = 24'(size);
    i_vsync = 1'b1;
    step(2);
    check("frame_start_lines", o_lines, 0);
    check("frame_start_ovf", o_overflow, 0);
    for (int l = 0; l < nl; l++) begin
      i_wr_ready = (l == drop_l) ? 2'b00 : 2'b11;
      if (l != drop_l) push_line(npix, base, stride, size);
      send_line(npix, base, stride);
      i_wr_ready = 2'b11;
    end
    i_vsync = 1'b0;
    t = 0;
    while (n_cap == c0 && t < 100) begin
      step();
      t++;
    end
    step(3);
    check("captured_once", n_cap - c0, 1);
    check("act_released", o_wr_activate, 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    int         npix;
    logic [7:0] base;
    int         size;
    int         exp_words;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[7];
  int   n0;
  logic [31:0] exp16;

  initial begin
    tbl[0] = '{8, 8'h01, 16, 2, 1'b0};
    tbl[1] = '{6, 8'hA1, 16, 2, 1'b0};
    tbl[2] = '{8, 8'h01, 1, 1, 1'b1};
    tbl[3] = '{1, 8'h55, 16, 1, 1'b0};
    tbl[4] = '{5, 8'h10, 2, 2, 1'b0};
    tbl[5] = '{9, 8'h20, 2, 2, 1'b1};
    tbl[6] = '{4, 8'hF0, 0, 0, 1'b1};

    rst_n = 1'b0;
    i_enable = 1'b0;
    i_line_count = '0;
    i_vsync = 1'b0;
    i_hsync = 1'b0;
    i_pix_data = '0;
    i_wr_ready = 2'b11;
    i_wr_size = 24'd16;
    step(3);
    check("rst_ctl", {o_wr_activate, o_wr_stb, o_busy, o_captured,
                      o_overflow, o_lines, o_dropped}, 0);
    check("rst_data", o_wr_data, 0);
    rst_n = 1'b1;
    i_enable = 1'b1;
    step(3);
    check("busy_after_enable", o_busy, 1);

    i_line_count = 16'd2;
    n0 = n_stb;
    run_frame(2, 8, 8'h01, 8'h01, 16, -1);
    check("basic_lines", o_lines, 2);
    check("basic_stbs", n_stb - n0, 4);
    check("basic_ovf", o_overflow, 0);

    // word latency, buffer-1 claim and release ordering
    i_line_count = 16'd1;
    i_wr_ready = 2'b10;
    i_vsync = 1'b1;
    step(2);
    push_line(4, 8'h40, 8'h01, 16);
    for (int i = 0; i < 4; i++) begin
      i_hsync = 1'b1;
      i_pix_data = 8'h40 + 8'(i);
      step();
    end
    check("stb_latency", o_wr_stb, 1);
    check("claim_bit1", o_wr_activate, 2'b10);
    i_hsync = 1'b0;
    step();
    check("stb_one_cycle", o_wr_stb, 0);
    check("act_held_in_flush", o_wr_activate, 2'b10);
    step();
    check("act_release", o_wr_activate, 0);
    check("lines_after_release", o_lines, 1);
    i_wr_ready = 2'b11;
    i_vsync = 1'b0;
    step(6);

    for (int v = 0; v < 7; v++) begin
      n0 = n_stb;
      run_frame(1, tbl[v].npix, tbl[v].base, 8'h01, tbl[v].size, -1);
      check("vec_words", n_stb - n0, tbl[v].exp_words);
      check("vec_ovf", o_overflow, tbl[v].exp_ovf);
      check("vec_lines", o_lines, 1);
    end

    i_line_count = 16'd3;
    n0 = n_stb;
    run_frame(3, 8, 8'h60, 8'h01, 16, 1);
    check("starve_dropped", o_dropped, 1);
    check("starve_lines", o_lines, 3);
    check("starve_stbs", n_stb - n0, 4);

    i_line_count = 16'd0;
    n0 = n_stb;
    run_frame(5, 4, 8'h70, 8'h01, 16, -1);
    check("unbounded_lines", o_lines, 5);
    check("unbounded_stbs", n_stb - n0, 5);

`ifdef CAM_LINE_PACKER_BIG_ENDIAN_EN
    exp16 = 32'h1111_2222;
`else
    exp16 = 32'h2222_1111;
`endif
    i_line_count = 16'd1;
    q16.delete();
    run_frame(1, 2, 8'h11, 8'h11, 16, -1);
    check("w16_count", q16.size(), 1);
    check("w16_data", (q16.size() > 0) ? q16[0] : 32'hx, exp16);
    check("dut16_status", {act16, busy16, ovf16, dropped16, lines16},
          {2'b00, 1'b1, 1'b0, 16'd0, 16'd1});

    i_wr_size = 24'd16;
    i_vsync = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++) begin
      i_hsync = 1'b1;
      i_pix_data = 8'h90 + 8'(i);
      step();
    end
    check("act_before_rst", o_wr_activate, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("midline_rst_ctl", {o_wr_activate, o_wr_stb, o_busy, o_captured,
                              o_overflow, o_lines, o_dropped}, 0);
    check("midline_rst_data", o_wr_data, 0);
    i_hsync = 1'b0;
    i_vsync = 1'b0;
    i_pix_data = '0;
    step(2);
    rst_n = 1'b1;
    step(3);
    n0 = n_stb;
    run_frame(1, 8, 8'h31, 8'h01, 16, -1);
    check("post_rst_lines", o_lines, 1);
    check("post_rst_stbs", n_stb - n0, 2);

    step(5);
    check("sb_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cam_line_packer.md
Name: cam_line_packer

Overview:
- Parametrised successor to the camera line reader. Samples a parallel camera bus (vsync/hsync/pixel data) in the pixel clock domain.
- Packs PIX_W-bit pixels into DATA_W-bit words and writes one video line per ping-pong FIFO buffer.
- Frames are bounded by vsync. The frame's line budget is programmable. Overflow and dropped lines are reported as sticky status.
- Sits between the camera pads and the write side of the existing ping-pong FIFO; the wishbone camera slave owns the control/status.

Parameters:
- PIX_W, 8: pixel width in bits.
- DATA_W, 32: FIFO word width. Must be an integer multiple of PIX_W. PPW = DATA_W/PIX_W pixels per word.
- LINE_W, 16: width of line counters.

Ports:
- clk, input, 1: pixel clock. All logic is on this clock.
- rst_n, input, 1: asynchronous, active-low reset.
- i_enable, input, 1: capture enable, sampled at frame boundaries.
- i_line_count, input, LINE_W: lines per frame. 0 = unbounded, ends at vsync fall.
- i_vsync, input, 1: frame valid, active high.
- i_hsync, input, 1: line valid, active high.
- i_pix_data, input, PIX_W: pixel data, valid when i_hsync=1.
- i_wr_ready, input, 2: ping-pong buffer free flags.
- o_wr_activate, output, 2: buffer ownership, one-hot or 0.
- i_wr_size, input, 24: capacity of the owned buffer in words.
- o_wr_stb, output, 1: write strobe.
- o_wr_data, output, DATA_W: packed word.
- o_busy, output, 1: high in any state other than IDLE.
- o_captured, output, 1: one-cycle pulse at frame end.
- o_lines, output, LINE_W: lines seen in the current/last frame.
- o_overflow, output, 1: sticky; cleared at next frame start.
- o_dropped, output, LINE_W: lines dropped for lack of a buffer in the current frame.

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-line):
  - state=IDLE.
  - o_wr_activate=0, o_wr_stb=0, o_wr_data=0, o_busy=0, o_captured=0, o_lines=0, o_overflow=0, o_dropped=0.
  - Pack index and word count are cleared. A partially written buffer is abandoned.
- States:
  - IDLE -> WAIT_FRAME when i_enable=1.
  - WAIT_FRAME: waits for a rising edge of i_vsync, i.e. i_vsync=1 with the previous sample 0. A frame already in progress at enable is skipped. On the edge: clear o_lines, o_dropped, o_overflow; go to WAIT_LINE.
  - WAIT_LINE:
    - Rising edge of hsync with a buffer free: claim a buffer. Take bit 0 if i_wr_ready[0], else bit 1. o_wr_activate is set in the same cycle the edge is sampled. Go to CAPTURE.
    - Rising edge of hsync with no buffer free (i_wr_ready=0 and activate=0): go to DROP.
    - i_vsync falls: go to DONE.
  - CAPTURE:
    - Each cycle with i_hsync=1, store the pixel at lane index k: bits [k*PIX_W +: PIX_W], first pixel in lane 0.
    - When k=PPW-1: o_wr_stb=1 and o_wr_data=packed word on the next cycle. Word count increments and k wraps to 0.
    - If the word count already equals i_wr_size: no strobe, the word is discarded, o_overflow=1. Remaining pixels of the line are ignored.
    - i_hsync falls: go to FLUSH.
  - FLUSH:
    - If k!=0, one strobe with the unfilled upper lanes zeroed; this strobe is also subject to the size check.
    - Next cycle: o_wr_activate=0, o_lines increments, and k and the word count are cleared.
    - If i_line_count!=0 and o_lines reaches i_line_count: go to DONE. Otherwise go to WAIT_LINE.
    - A buffer with zero words (hsync pulse shorter than one sample) is still released. o_lines counts it.
  - DROP: waits for i_hsync=0. o_dropped increments and o_lines increments. Then applies the same line-budget check as FLUSH.
  - DONE: o_captured pulses for 1 cycle. Go to WAIT_FRAME if i_enable=1, else IDLE.
- vsync falling mid-line (in CAPTURE) is treated as hsync falling: FLUSH runs, then DONE.
- Extra lines after the budget is met are ignored until the next vsync rising edge.
- i_enable deasserted mid-frame: the current frame completes normally, then IDLE.
- Timing:
  - Latency from the last pixel of a word to o_wr_stb: 1 cycle.
  - The line's final strobe precedes the activate release by at least 1 cycle.
- Counter widths: o_lines and o_dropped saturate at all-ones. The word count is 24 bits and is compared unsigned against i_wr_size.

Optional Feature:
- Macro CAM_LINE_PACKER_BIG_ENDIAN_EN.
- Defined: the first pixel of a word goes to the most-significant lane, [DATA_W-1 -: PIX_W]. Zero padding in a flushed word then occupies the low lanes.
- Undefined: the little-endian lane order described above.
- Nothing else changes.

Test Plan:
- Bounded frame, basic packing:
  - Stimulus: defaults; i_line_count=2; both buffers ready; i_wr_size=16. Lines of 8 pixels 0x01..0x08.
  - Response per line: 2 strobes with data 0x04030201 then 0x08070605. Activate released after the line.
  - Response per frame: o_lines=2; o_captured pulses once; o_overflow=0.
- Partial word flush: a 6-pixel line 0xA1..0xA6 -> strobes 0xA4A3A2A1 then 0x0000A6A5.
- Overflow: i_wr_size=1 with an 8-pixel line -> exactly one strobe, 0x04030201. o_overflow=1 until the next vsync rise.
- Buffer starvation: i_wr_ready=0 for the whole of line 2 of 3 -> o_dropped=1, o_lines=3, no strobes on line 2, o_captured pulses.
- Reset mid-line: drop rst_n after 3 pixels -> all outputs 0 immediately. After release with i_enable=1, the next frame captures cleanly.
- Parameter and option coverage:
  - PIX_W=16, DATA_W=32 with CAM_LINE_PACKER_BIG_ENDIAN_EN: pixels 0x1111, 0x2222 -> word 0x11112222.
  - i_line_count=0: the frame ends on vsync fall after 5 lines with o_lines=5.
